calc1_port_responder: RTL and testbench

- Single-port, cycle-accurate responder for the calc1 request protocol.
- Accepts a command with operand 1, then operand 2 on the following cycle.
- Computes the result and returns a one-cycle response/data pair after a fixed latency.
- Serves as the synthesizable far end of the calc1 request interface, for stand-alone driver bring-up and as a per-port building block for a multi-port calculator.

---
 rtl/calc1_pkg.sv | 26 ++
 rtl/calc1_alu.sv | 52 +++++
 rtl/calc1_port_responder.sv | 129 ++++++++++++
 tb/tb_calc1_port_responder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/calc1_pkg.sv
// Shared command/response codes and FSM state encoding for the calc1 responder.
package calc1_pkg;

  localparam int CMD_W = 4;
  localparam int RSP_W = 2;
  localparam int CNT_W = 4;

  localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
  localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
  localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
  localparam logic [CMD_W-1:0] CMD_LSH = 4'd5;
  localparam logic [CMD_W-1:0] CMD_RSH = 4'd6;

  localparam logic [RSP_W-1:0] RSP_NONE = 2'd0;
  localparam logic [RSP_W-1:0] RSP_SUCC = 2'd1;
  localparam logic [RSP_W-1:0] RSP_INOF = 2'd2;
  localparam logic [RSP_W-1:0] RSP_IERR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OP2  = 2'd1,
    ST_EXEC = 2'd2,
    ST_RESP = 2'd3
  } state_e;

endpackage

// File: rtl/calc1_alu.sv
// Combinational calc1 ALU: arithmetic, overflow/underflow and invalid-command rules.
module calc1_alu
  import calc1_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [CMD_W-1:0]  i_cmd,
  input  logic [DATA_W-1:0] i_op1,
  input  logic [DATA_W-1:0] i_op2,
  output logic [RSP_W-1:0]  o_resp,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W:0]   w_sum;
  logic [4:0]        w_shamt;

  assign w_sum   = {1'b0, i_op1} + {1'b0, i_op2};
  assign w_shamt = i_op2[4:0];

  always_comb begin
    o_resp = RSP_INOF;
    o_data = '0;
    case (i_cmd)
      CMD_ADD: begin
        if (!w_sum[DATA_W]) begin
          o_resp = RSP_SUCC;
          o_data = w_sum[DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        // Unsigned underflow is reported rather than wrapped.
        if (i_op2 <= i_op1) begin
          o_resp = RSP_SUCC;
          o_data = i_op1 - i_op2;
        end
      end
      CMD_LSH: begin
        o_resp = RSP_SUCC;
        o_data = i_op1 << w_shamt;
      end
      CMD_RSH: begin
        o_resp = RSP_SUCC;
        o_data = i_op1 >> w_shamt;
      end
      default: begin
        o_resp = RSP_INOF;
        o_data = '0;
      end
    endcase
  end

endmodule

// File: rtl/calc1_port_responder.sv
// Single-port calc1 responder: command+op1, op2, fixed-latency one-cycle response.
// Optional macro CALC1_PROTO_CHECK_EN turns commands seen during EXEC into an internal-error response.
module calc1_port_responder
  import calc1_pkg::*;
#(
  parameter int LATENCY = 3,
  parameter int DATA_W  = 32
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [CMD_W-1:0]  req_cmd_in,
  input  logic [DATA_W-1:0] req_data_in,
  output logic [RSP_W-1:0]  out_resp,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  state_e            r_state, w_state_nxt;
  logic [CMD_W-1:0]  r_cmd, w_cmd_nxt;
  logic [DATA_W-1:0] r_op1, w_op1_nxt;
  logic [DATA_W-1:0] r_op2, w_op2_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [RSP_W-1:0]  r_resp, w_resp_nxt;
  logic [DATA_W-1:0] r_data, w_data_nxt;
  logic              r_viol, w_viol_nxt;
  logic              w_cmd_valid;
  logic              w_viol_hit;
  logic [RSP_W-1:0]  w_alu_resp;
  logic [DATA_W-1:0] w_alu_data;

  assign w_cmd_valid = (req_cmd_in != CMD_NOP);

`ifdef CALC1_PROTO_CHECK_EN
  assign w_viol_hit = (r_state == ST_EXEC) && w_cmd_valid;
`else
  assign w_viol_hit = 1'b0;
`endif

  calc1_alu #(.DATA_W(DATA_W)) u_alu (
    .i_cmd  (r_cmd),
    .i_op1  (r_op1),
    .i_op2  (r_op2),
    .o_resp (w_alu_resp),
    .o_data (w_alu_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cmd_nxt   = r_cmd;
    w_op1_nxt   = r_op1;
    w_op2_nxt   = r_op2;
    w_cnt_nxt   = r_cnt;
    w_resp_nxt  = r_resp;
    w_data_nxt  = r_data;
    w_viol_nxt  = r_viol;
    case (r_state)
      ST_IDLE: begin
        w_viol_nxt = 1'b0;
        if (w_cmd_valid) begin
          w_cmd_nxt   = req_cmd_in;
          w_op1_nxt   = req_data_in;
          w_state_nxt = ST_OP2;
        end
      end
      ST_OP2: begin
        w_op2_nxt   = req_data_in;
        w_cnt_nxt   = CNT_W'(LATENCY - 1);
        w_state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        w_viol_nxt = r_viol | w_viol_hit;
        if (r_cnt == '0) begin
          // A command on the registering edge itself still counts as a violation.
          if (r_viol || w_viol_hit) begin
            w_resp_nxt = RSP_IERR;
            w_data_nxt = '0;
          end else begin
            w_resp_nxt = w_alu_resp;
            w_data_nxt = w_alu_data;
          end
          w_state_nxt = ST_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_RESP: begin
        w_resp_nxt = RSP_NONE;
        w_data_nxt = '0;
        w_viol_nxt = 1'b0;
        // The edge leaving RESP may already accept the next command.
        if (w_cmd_valid) begin
          w_cmd_nxt   = req_cmd_in;
          w_op1_nxt   = req_data_in;
          w_state_nxt = ST_OP2;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cmd   <= CMD_NOP;
      r_op1   <= '0;
      r_op2   <= '0;
      r_cnt   <= '0;
      r_resp  <= RSP_NONE;
      r_data  <= '0;
      r_viol  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cmd   <= w_cmd_nxt;
      r_op1   <= w_op1_nxt;
      r_op2   <= w_op2_nxt;
      r_cnt   <= w_cnt_nxt;
      r_resp  <= w_resp_nxt;
      r_data  <= w_data_nxt;
      r_viol  <= w_viol_nxt;
    end
  end

  assign out_resp = r_resp;
  assign out_data = r_data;
  assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_calc1_port_responder.sv
// Directed plus randomized bench for calc1_port_responder against a behavioural model.
module tb_calc1_port_responder;

  localparam int LAT = 3;
  localparam int DW  = 32;

  logic          c_clk = 1'b0;
  logic          reset;
  logic [3:0]    req_cmd_in;
  logic [DW-1:0] req_data_in;
  logic [1:0]    out_resp;
  logic [DW-1:0] out_data;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  calc1_port_responder #(.LATENCY(LAT), .DATA_W(DW)) dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .req_cmd_in  (req_cmd_in),
    .req_data_in (req_data_in),
    .out_resp    (out_resp),
    .out_data    (out_data),
    .busy        (busy)
  );

  always #5 c_clk = ~c_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Behavioural reference: returns {resp, data} from the arithmetic rules.
  function automatic logic [33:0] ref_model(input int cmd, input logic [31:0] a, input logic [31:0] b);
    longint sum;
    longint shl;
    case (cmd)
      1: begin
        sum = longint'(a) + longint'(b);
        if (sum > 64'hFFFF_FFFF) return {2'd2, 32'd0};
        return {2'd1, sum[31:0]};
      end
      2: begin
        if (b > a) return {2'd2, 32'd0};
        return {2'd1, a - b};
      end
      5: begin
        shl = longint'(a) << (b % 32);
        return {2'd1, shl[31:0]};
      end
      6: return {2'd1, a >> (b % 32)};
      default: return {2'd2, 32'd0};
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic idle_gap(input int n);
    req_cmd_in = 4'd0;
    for (int i = 0; i < n; i++) begin
      tick();
      check("idle_resp", 64'(out_resp), 64'd0);
      check("idle_data", 64'(out_data), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
    end
  endtask

  // Drives one transaction; returns during the response cycle so the next one may follow back-to-back.
  task automatic txn(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                     input logic [1:0] er, input logic [31:0] ed, input bit intrude);
    req_cmd_in  = cmd;
    req_data_in = a;
    tick();
    check("op2_busy", 64'(busy), 64'd1);
    check("op2_resp", 64'(out_resp), 64'd0);
    req_cmd_in  = 4'($urandom_range(0, 15));
    req_data_in = b;
    tick();
    req_data_in = $urandom;
    for (int k = 1; k < LAT; k++) begin
      if (intrude && k == 1) begin
        req_cmd_in  = 4'd1;
        req_data_in = 32'd1;
      end else if (intrude && k == 2) begin
        req_cmd_in  = 4'd0;
        req_data_in = 32'd1;
      end else begin
        req_cmd_in = 4'd0;
      end
      tick();
      check("exec_resp", 64'(out_resp), 64'd0);
      check("exec_data", 64'(out_data), 64'd0);
      check("exec_busy", 64'(busy), 64'd1);
    end
    req_cmd_in = 4'd0;
    tick();
    check("resp_code", 64'(out_resp), 64'(er));
    check("resp_data", 64'(out_data), 64'(ed));
    check("resp_busy", 64'(busy), 64'd1);
  endtask

  initial begin
    logic [33:0] exp_v;
    logic [3:0]  cmd_tbl [8];
    logic [3:0]  rc;
    logic [31:0] ra, rb;
    logic [1:0]  intr_resp;
    logic [31:0] intr_data;

    cmd_tbl = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd3, 4'd4, 4'd7, 4'd15};
    reset       = 1'b0;
    req_cmd_in  = 4'd0;
    req_data_in = '0;
    #12;
    check("rst_resp", 64'(out_resp), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    tick();
    reset = 1'b1;
    idle_gap(2);

    // Basic ADD and boundary arithmetic, partly back-to-back
    txn(4'd1, 32'd255, 32'd1, 2'd1, 32'd256, 1'b0);
    idle_gap(1);
    txn(4'd1, 32'hFFFF_FFFF, 32'd1, 2'd2, 32'd0, 1'b0);
    txn(4'd2, 32'd100, 32'd1, 2'd1, 32'd99, 1'b0);
    txn(4'd2, 32'd1, 32'd2, 2'd2, 32'd0, 1'b0);
    idle_gap(1);
    txn(4'd5, 32'd1, 32'd33, 2'd1, 32'd2, 1'b0);
    txn(4'd6, 32'h8000_0000, 32'd31, 2'd1, 32'd1, 1'b0);
    idle_gap(1);
    txn(4'd3, 32'd5, 32'd7, 2'd2, 32'd0, 1'b0);
    idle_gap(1);

    // Asynchronous reset in the middle of EXEC discards the transaction
    req_cmd_in  = 4'd1;
    req_data_in = 32'd1;
    tick();
    req_cmd_in  = 4'd0;
    req_data_in = 32'd2;
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_resp", 64'(out_resp), 64'd0);
    check("arst_data", 64'(out_data), 64'd0);
    tick();
    tick();
    reset = 1'b1;
    idle_gap(LAT + 3);
    txn(4'd1, 32'd1, 32'd2, 2'd1, 32'd3, 1'b0);
    idle_gap(1);

    // Command intruding during EXEC
`ifdef CALC1_PROTO_CHECK_EN
    intr_resp = 2'd3;
    intr_data = 32'd0;
`else
    intr_resp = 2'd1;
    intr_data = 32'd0;
`endif
    txn(4'd2, 32'd4, 32'd4, intr_resp, intr_data, 1'b1);
    idle_gap(2 * LAT + 2);

    // Randomized transactions against the reference model
    for (int i = 0; i < 24; i++) begin
      rc = cmd_tbl[$urandom_range(0, 7)];
      case ($urandom_range(0, 3))
        0:       ra = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        1:       ra = 32'($urandom_range(0, 8));
        default: ra = $urandom;
      endcase
      rb = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      exp_v = ref_model(int'(rc), ra, rb);
      txn(rc, ra, rb, exp_v[33:32], exp_v[31:0], 1'b0);
      if ($urandom_range(0, 1) == 0) idle_gap(1);
    end
    idle_gap(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
